// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bit4_adder.sv
// 4-bit ripple-carry adder, one full adder per bit.
// Latency: combinational.
// Backpressure: none.
module bit4_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        c_out = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide add (optionally subtract, NSA_SUB_EN) using one 4-bit adder stepped over nibbles, LSB first.
// Latency: WIDTH/4 cycles from accept to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready low whenever an operation is in flight.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (clog2(NIB) < 1) ? 1 : clog2(NIB);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-5:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [3:0]       nib_sum;
    logic             nib_c;

    bit4_adder u_add (
        .x     (a_sh[3:0]),
        .y     (b_sh[3:0]),
        .c_in  (carry),
        .sum   (nib_sum),
        .c_out (nib_c)
    );

    // Newest nibble enters at the top; after NIB steps the word is aligned.
    assign sum_nx   = {nib_sum, sum_sh};
    assign in_ready = (state == IDLE) && !rst;

`ifndef NSA_SUB_EN
    logic unused_op;
    assign unused_op = op;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef NSA_SUB_EN
                        // a - b computed as a + ~b + 1
                        if (op == OP_SUB) begin
                            b_sh  <= ~b;
                            carry <= 1'b1;
                        end else begin
                            b_sh  <= b;
                            carry <= c_in;
                        end
`else
                        b_sh  <= b;
                        carry <= c_in;
`endif
                    end
                end
                RUN: begin
                    a_sh   <= {4'h0, a_sh[WIDTH-1:4]};
                    b_sh   <= {4'h0, b_sh[WIDTH-1:4]};
                    sum_sh <= sum_nx[WIDTH-1:4];
                    carry  <= nib_c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(NIB - 1)) begin
                        sum       <= sum_nx;
                        c_out     <= nib_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16); expected results queued at accept, checked by a monitor.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops and compares whenever a result is handed over.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                chk("rdy_vld_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual sum=%h c_out=%b required=no result", sum, c_out);
                    end else begin
                        e = q.pop_front();
                        chk("result_sum", {16'd0, sum}, {16'd0, e.s});
                        chk("result_c_out", {31'd0, c_out}, {31'd0, e.c});
                    end
                end
            end
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic iop,
                         input logic [WIDTH-1:0] es, input logic ec,
                         input int hold, input bit scramble);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        a        = ia;
        b        = ib;
        c_in     = ic;
        op       = iop;
        in_valid = 1'b1;
        @(posedge clk);
        q.push_back({es, ec});
        #1;
        if (!scramble) in_valid = 1'b0;
        for (int k = 1; k <= NIB; k++) begin
            if (scramble) begin
                a    = WIDTH'($urandom);
                b    = WIDTH'($urandom);
                c_in = ~c_in;
                op   = ~op;
            end
            @(posedge clk);
            #1;
            if (k < NIB) begin
                chk("out_valid_early", {31'd0, out_valid}, 32'd0);
                chk("in_ready_run", {31'd0, in_ready}, 32'd0);
                chk("busy_run", {31'd0, busy}, 32'd1);
            end else begin
                chk("out_valid_at_nib", {31'd0, out_valid}, 32'd1);
            end
        end
        in_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, {16'd0, es});
            chk("hold_c_out", {31'd0, c_out}, {31'd0, ec});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_busy", {31'd0, busy}, 32'd0);
        chk("retain_sum", {16'd0, sum}, {16'd0, es});
        chk("retain_c_out", {31'd0, c_out}, {31'd0, ec});
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        op        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_sum", {16'd0, sum}, 32'd0);
        chk("reset_c_out", {31'd0, c_out}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
        do_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 5, 1'b0);
        do_op(16'h4321, 16'h1111, 1'b1, 1'b0, 16'h5433, 1'b0, 0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 1'b0);
        do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 0, 1'b0);

        // Abort an operation in its second nibble step; nothing must come out.
        a        = 16'h1111;
        b        = 16'h2222;
        c_in     = 1'b0;
        op       = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 0, 1'b0);

`ifdef NSA_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 0, 1'b0);
`else
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
